// File: rtl/uart_cmd_parser_if.sv
// Bundles the UART byte handshake and the ALU operand/result bus of uart_cmd_parser.
interface uart_cmd_parser_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);

  logic [NB_DATA-1:0] i_rx;
  logic               i_rx_done;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_data;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic               o_valid;
  logic [NB_DATA-1:0] i_result;
  logic               o_busy;
  logic               o_err;

  // Parser side: consumes RX bytes and the ALU result, drives TX and the ALU inputs.
  modport slave (
    input  i_rx, i_rx_done, i_tx_done, i_result,
    output o_tx_start, o_data, o_operation, o_datoA, o_datoB, o_valid, o_busy, o_err
  );

  // Environment side: UART RX/TX and the ALU.
  modport master (
    output i_rx, i_rx_done, i_tx_done, i_result,
    input  o_tx_start, o_data, o_operation, o_datoA, o_datoB, o_valid, o_busy, o_err
  );

endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns (tag, payload) byte pairs into ALU operands and an
// opcode, fires the ALU on an opcode frame and returns the result (or an error
// code for an unknown tag) through UART_TX with a start/done handshake.
// Also flags inter-byte timeouts and bytes arriving while a command is in flight.
module uart_cmd_parser #(
  parameter int unsigned        NB_DATA  = 8,
  parameter int unsigned        NB_OP    = 6,
  parameter logic [NB_DATA-1:0] TAG_A    = 8'h08,
  parameter logic [NB_DATA-1:0] TAG_B    = 8'h10,
  parameter logic [NB_DATA-1:0] TAG_OP   = 8'h20,
  parameter logic [NB_DATA-1:0] ERR_CODE = 8'hEE,
  parameter int unsigned        ALU_LAT  = 1,
  parameter int unsigned        NB_TMO   = 16,
  parameter int unsigned        TIMEOUT  = 50000
) (
  input logic              clk,
  input logic              i_rst,
  uart_cmd_parser_if.slave bus
);

  // Latency counter only needs to reach ALU_LAT-1; keep at least one bit.
  localparam int unsigned NB_LAT = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [NB_LAT-1:0] LAT_LAST = NB_LAT'(ALU_LAT - 1);
  localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t             state;
  logic [NB_DATA-1:0] tag_q;
  logic [NB_TMO-1:0]  timer;
  logic [NB_LAT-1:0]  lat_cnt;

  // Frame decode, ALU launch, result capture and TX handshake; all outputs registered.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state           <= IDLE;
      tag_q           <= '0;
      timer           <= '0;
      lat_cnt         <= '0;
      bus.o_tx_start  <= 1'b0;
      bus.o_data      <= '0;
      bus.o_operation <= '0;
      bus.o_datoA     <= '0;
      bus.o_datoB     <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_err       <= 1'b0;
    end else begin
      // Strobes fall back to zero unless a branch below raises them.
      bus.o_valid    <= 1'b0;
      bus.o_tx_start <= 1'b0;
      bus.o_err      <= 1'b0;

      // A byte arriving while a command is in flight is dropped and flagged.
      if (bus.i_rx_done && (state inside {EXEC, SEND, WAIT_TX})) begin
        bus.o_err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (bus.i_rx_done) begin
            tag_q      <= bus.i_rx;
            timer      <= '0;
            state      <= PAYLOAD;
            bus.o_busy <= 1'b1;
          end
        end

        PAYLOAD: begin
          // A payload on the final timer cycle wins over the timeout.
          if (bus.i_rx_done) begin
            if (tag_q == TAG_A) begin
              bus.o_datoA <= bus.i_rx;
              state       <= IDLE;
              bus.o_busy  <= 1'b0;
            end else if (tag_q == TAG_B) begin
              bus.o_datoB <= bus.i_rx;
              state       <= IDLE;
              bus.o_busy  <= 1'b0;
            end else if (tag_q == TAG_OP) begin
              bus.o_operation <= bus.i_rx[NB_OP-1:0];
              bus.o_valid     <= 1'b1;
              lat_cnt         <= '0;
              state           <= EXEC;
            end else begin
              bus.o_err  <= 1'b1;
              bus.o_data <= ERR_CODE;
              state      <= SEND;
            end
          end else if (timer == TMO_LAST) begin
            bus.o_err  <= 1'b1;
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end else begin
            timer <= timer + NB_TMO'(1);
          end
        end

        EXEC: begin
          // Operands stay frozen here while the ALU settles for ALU_LAT clocks.
          if (lat_cnt == LAT_LAST) begin
            bus.o_data <= bus.i_result;
            state      <= SEND;
          end else begin
            lat_cnt <= lat_cnt + NB_LAT'(1);
          end
        end

        SEND: begin
          bus.o_tx_start <= 1'b1;
          state          <= WAIT_TX;
        end

        WAIT_TX: begin
          // o_data is left untouched until UART_TX reports completion.
          if (bus.i_tx_done) begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
